// File: rtl/tone_sequencer.sv
// tone_sequencer: two-voice song ROM player that feeds the note generator's
// half-period dividers at a fixed beat rate (divider 1 = silence).
// Ports: clk, rst (async, active-high); play_en (level), rewind (pulse),
//   loop_en (level); note_div_left/right [21:0], beat_idx, playing, done.
// Option: define TONE_SEQ_GAP_EN to silence the last GAP_CYC cycles of
//   every beat (articulation gap).
module tone_sequencer #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int BEAT_DIV = 12_500_000,
  parameter int SONG_LEN = 64,
  parameter int GAP_CYC  = 1_000_000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        play_en,
  input  logic                        rewind,
  input  logic                        loop_en,
  output logic [21:0]                 note_div_left,
  output logic [21:0]                 note_div_right,
  output logic [$clog2(SONG_LEN)-1:0] beat_idx,
  output logic                        playing,
  output logic                        done
);

  localparam int AW = $clog2(SONG_LEN);
  localparam int CW = (BEAT_DIV > 2) ? $clog2(BEAT_DIV) : 1;
  localparam logic [CW-1:0] BEAT_LAST = CW'(BEAT_DIV - 1);
  localparam logic [CW-1:0] GAP_START = CW'(BEAT_DIV - GAP_CYC);
  localparam logic [AW-1:0] IDX_LAST  = AW'(SONG_LEN - 1);

`ifdef TONE_SEQ_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    PAUSE,
    DONE
  } state_t;

  // Equal-tempered pitch, rounded to 0.01 Hz like the usual pitch table,
  // then converted to a half-period divider.
  function automatic logic [21:0] div_of(input int code);
    real semi;
    real f;
    real d;
    int  n;
    if (code < 1 || code > 24) return 22'd1;
    semi = 1.0594630943592953;
    f    = 440.0;
    n    = code - 10;
    for (int i = 0; i < n; i++) f = f * semi;
    for (int i = 0; i < -n; i++) f = f / semi;
    f = real'($rtoi(f * 100.0 + 0.5)) / 100.0;
    d = real'(CLK_HZ) / (2.0 * f);
    return 22'($rtoi(d + 0.5) - 1);
  endfunction

  // {left code, right code}
  function automatic logic [9:0] song(input logic [7:0] i);
    unique case (i)
      8'd0:    song = {5'd10, 5'd1};
      8'd1:    song = {5'd22, 5'd0};
      8'd2:    song = {5'd13, 5'd5};
      8'd3:    song = {5'd15, 5'd8};
      8'd4:    song = {5'd17, 5'd1};
      8'd5:    song = {5'd15, 5'd0};
      8'd6:    song = {5'd13, 5'd5};
      8'd7:    song = {5'd12, 5'd0};
      8'd8:    song = {5'd10, 5'd6};
      8'd9:    song = {5'd12, 5'd0};
      8'd10:   song = {5'd13, 5'd8};
      8'd11:   song = {5'd15, 5'd0};
      8'd12:   song = {5'd17, 5'd3};
      8'd13:   song = {5'd18, 5'd0};
      8'd14:   song = {5'd20, 5'd8};
      8'd15:   song = {5'd22, 5'd1};
      default: song = 10'd0;
    endcase
  endfunction

  logic [21:0] div_tab [32];

  for (genvar g = 0; g < 32; g++) begin : g_tab
    localparam logic [21:0] D = div_of(g);
    assign div_tab[g] = D;
  end

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] bcnt;
  logic [CW-1:0] bcnt_n;
  logic [AW-1:0] idx_n;
  logic          wrap;
  logic          gap;
  logic [9:0]    word;

  assign wrap = (bcnt == BEAT_LAST);
  assign gap  = GAP_EN && (bcnt >= GAP_START);
  assign word = song(8'(beat_idx));

  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    idx_n   = beat_idx;
    if (rewind) begin
      state_n = IDLE;
      bcnt_n  = '0;
      idx_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          bcnt_n = '0;
          idx_n  = '0;
          if (play_en) state_n = PLAY;
        end
        PLAY: begin
          if (wrap) begin
            // a beat wrap always completes, even if play_en just fell
            bcnt_n = '0;
            if (beat_idx == IDX_LAST && !loop_en) begin
              state_n = DONE;
            end else begin
              // power-of-two length: last+1 rolls over to 0
              idx_n = beat_idx + 1'b1;
              if (!play_en) state_n = PAUSE;
            end
          end else if (!play_en) begin
            state_n = PAUSE;
          end else begin
            bcnt_n = bcnt + 1'b1;
          end
        end
        PAUSE: begin
          if (play_en) state_n = PLAY;
        end
        DONE: begin
          state_n = DONE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      bcnt           <= '0;
      beat_idx       <= '0;
      playing        <= 1'b0;
      done           <= 1'b0;
      note_div_left  <= 22'd1;
      note_div_right <= 22'd1;
    end else begin
      state    <= state_n;
      bcnt     <= bcnt_n;
      beat_idx <= idx_n;
      playing  <= (state_n == PLAY);
      done     <= (state_n == DONE);
      if (state == PLAY && !gap) begin
        note_div_left  <= div_tab[word[9:5]];
        note_div_right <= div_tab[word[4:0]];
      end else begin
        note_div_left  <= 22'd1;
        note_div_right <= 22'd1;
      end
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: directed checks of tone_sequencer with a 10-cycle beat,
// 4-entry song and 3-cycle gap (gap expectations follow TONE_SEQ_GAP_EN).
module tb_tone_sequencer;

  localparam int A4 = 113635;
  localparam int C4 = 191109;
  localparam int A5 = 56817;

`ifdef TONE_SEQ_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        play_en;
  logic        rewind;
  logic        loop_en;
  logic [21:0] note_div_left;
  logic [21:0] note_div_right;
  logic [1:0]  beat_idx;
  logic        playing;
  logic        done;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  tone_sequencer #(
    .CLK_HZ  (100_000_000),
    .BEAT_DIV(10),
    .SONG_LEN(4),
    .GAP_CYC (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .play_en       (play_en),
    .rewind        (rewind),
    .loop_en       (loop_en),
    .note_div_left (note_div_left),
    .note_div_right(note_div_right),
    .beat_idx      (beat_idx),
    .playing       (playing),
    .done          (done)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic silent(input string tag);
    chk({tag, "_l"}, 32'(note_div_left), 32'd1);
    chk({tag, "_r"}, 32'(note_div_right), 32'd1);
  endtask

  initial begin
    logic gap_now;
    rst     = 1'b1;
    play_en = 1'b0;
    rewind  = 1'b0;
    loop_en = 1'b0;
    step(2);
    rst = 1'b0;
    silent("rst");
    chk("rst_idx", 32'(beat_idx), 32'd0);
    chk("rst_playing", 32'(playing), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // start playback
    play_en = 1'b1;
    step(1);
    chk("start_playing", 32'(playing), 32'd1);
    silent("start_pre");
    step(1);
    chk("e0_l", 32'(note_div_left), A4);
    chk("e0_r", 32'(note_div_right), C4);
    step(8);
    chk("beat0_last_idx", 32'(beat_idx), 32'd0);
    step(1);
    chk("beat1_idx", 32'(beat_idx), 32'd1);
    chk("beat1_lag_l", 32'(note_div_left), A4);
    step(1);
    chk("e1_l", 32'(note_div_left), A5);
    chk("e1_r", 32'(note_div_right), 32'd1);

    // pause at bcnt 4 for 20 cycles
    step(3);
    play_en = 1'b0;
    step(1);
    chk("pause_playing", 32'(playing), 32'd0);
    step(1);
    silent("pause");
    step(18);
    chk("pause_idx", 32'(beat_idx), 32'd1);
    silent("pause_end");
    play_en = 1'b1;
    step(1);
    chk("resume_playing", 32'(playing), 32'd1);
    step(5);
    chk("resume_6_idx", 32'(beat_idx), 32'd1);
    step(1);
    chk("resume_7_idx", 32'(beat_idx), 32'd2);

    // run to end of song, no loop
    step(19);
    chk("last_idx", 32'(beat_idx), 32'd3);
    chk("last_done", 32'(done), 32'd0);
    step(1);
    chk("done", 32'(done), 32'd1);
    chk("done_idx", 32'(beat_idx), 32'd3);
    chk("done_playing", 32'(playing), 32'd0);
    step(1);
    silent("done");
    play_en = 1'b0;
    step(3);
    play_en = 1'b1;
    step(3);
    chk("done_hold", 32'(done), 32'd1);
    chk("done_hold_idx", 32'(beat_idx), 32'd3);
    chk("done_hold_playing", 32'(playing), 32'd0);
    play_en = 1'b0;
    rewind  = 1'b1;
    step(1);
    rewind = 1'b0;
    chk("rew_done", 32'(done), 32'd0);
    chk("rew_idx", 32'(beat_idx), 32'd0);
    chk("rew_playing", 32'(playing), 32'd0);
    step(1);
    silent("rew");

    // looping playback
    loop_en = 1'b1;
    play_en = 1'b1;
    step(1);
    chk("loop_playing", 32'(playing), 32'd1);
    for (int k = 2; k <= 40; k++) begin
      step(1);
      chk("loop_no_done", 32'(done), 32'd0);
    end
    chk("loop_last_idx", 32'(beat_idx), 32'd3);
    step(1);
    chk("loop_wrap_idx", 32'(beat_idx), 32'd0);
    chk("loop_wrap_playing", 32'(playing), 32'd1);
    chk("loop_wrap_done", 32'(done), 32'd0);

    // rewind coinciding with a beat wrap
    step(9);
    rewind  = 1'b1;
    play_en = 1'b0;
    step(1);
    rewind = 1'b0;
    chk("rew_wrap_idx", 32'(beat_idx), 32'd0);
    chk("rew_wrap_playing", 32'(playing), 32'd0);
    step(1);
    silent("rew_wrap");

    // async reset mid-beat
    play_en = 1'b1;
    step(15);
    chk("pre_rst_idx", 32'(beat_idx), 32'd1);
    chk("pre_rst_l", 32'(note_div_left), A5);
    #2;
    rst = 1'b1;
    #1;
    silent("arst");
    chk("arst_idx", 32'(beat_idx), 32'd0);
    chk("arst_playing", 32'(playing), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    #2;
    rst     = 1'b0;
    loop_en = 1'b0;
    play_en = 1'b1;

    // articulation gap: silent after cycles with bcnt 7..9 when enabled
    step(1);
    chk("gap_playing", 32'(playing), 32'd1);
    for (int k = 2; k <= 12; k++) begin
      step(1);
      gap_now = GAP && (k >= 9) && (k <= 11);
      if (k == 12) begin
        chk("gap_e1_l", 32'(note_div_left), A5);
        chk("gap_e1_r", 32'(note_div_right), 32'd1);
      end else begin
        chk("gap_l", 32'(note_div_left), gap_now ? 32'd1 : A4);
        chk("gap_r", 32'(note_div_right), gap_now ? 32'd1 : C4);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Melody sequencer that drives the note generator's `note_div_left` / `note_div_right` inputs. It steps through an internal two-voice song ROM at a fixed beat rate. Each 5-bit note code is converted to a 22-bit half-period divider, and the divider value 1 is emitted for silence. It sits directly upstream of the note generator and is controlled by play/rewind/loop inputs from the board-level debounce/one-pulse logic.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000: clock frequency used to compute the divider table at elaboration.
- `BEAT_DIV`, 12_500_000: clock cycles per beat (8 beats/s).
- `SONG_LEN`, 64: number of ROM entries. Must be a power of two, 2..256.
- `GAP_CYC`, 1_000_000: articulation gap length in cycles. Only used with `TONE_SEQ_GAP_EN`; must be < `BEAT_DIV`.

Ports:
- `clk`  in  1  clock; all state is on the rising edge.
- `rst`  in  1  reset: asynchronous, active-high; clock: `clk`.
- `play_en`  in  1  level. High requests playback; low pauses.
- `rewind`  in  1  single-cycle pulse. Returns to start, IDLE.
- `loop_en`  in  1  level. Wraps to entry 0 at end of song instead of stopping.
- `note_div_left`  out  22  registered divider for the melody voice; 1 = silence.
- `note_div_right`  out  22  registered divider for the bass voice; 1 = silence.
- `beat_idx`  out  log2(SONG_LEN)  current ROM entry.
- `playing`  out  1  high in PLAY.
- `done`  out  1  high in DONE.

## Operation
Note codes:
- 0 = rest.
- 1..12 = C4..B4, chromatic.
- 13..24 = C5..B5.
- 25..31 = rest.

Divider values:
- Formula: div = round(CLK_HZ / (2·f)) − 1, where f is equal-tempered with A4 = 440 Hz.
- At 100 MHz: C4 (code 1) = 191109, A4 (10) = 113635, A5 (22) = 56817.
- Rest = 1.

Song ROM:
- Each entry is {left code[9:5], right code[4:0]}.
- Entry 0 = {10, 1} (A4 / C4). Entry 1 = {22, 0} (A5 / rest).
- The remaining entries are the team melody and are not used by the bench.

Beat counter `bcnt`:
- Counts 0..BEAT_DIV−1 in PLAY only.
- At BEAT_DIV−1 it wraps to 0 and `beat_idx` advances.

State machine (`rewind` has priority over every transition):
- IDLE: `bcnt` = 0, `beat_idx` = 0, outputs silent. `play_en` = 1 → PLAY.
- PLAY: counts and outputs ROM[`beat_idx`].
  - `play_en` = 0 → PAUSE; `bcnt` and `beat_idx` are held.
  - Wrap at `beat_idx` = SONG_LEN−1 with `loop_en` = 1: `beat_idx` → 0, stay in PLAY.
  - Wrap at `beat_idx` = SONG_LEN−1 with `loop_en` = 0: → DONE, `beat_idx` held at SONG_LEN−1.
- PAUSE: outputs silent, counters frozen. `play_en` = 1 → PLAY, resuming at the same `bcnt`.
- DONE: outputs silent, `done` = 1. Leaves only on `rewind` or `rst`. `play_en` is ignored.
- `rewind` in any state: next cycle state = IDLE, `bcnt` = 0, `beat_idx` = 0.

Edge cases:
- `play_en` falling in the same cycle as a beat wrap: the wrap completes, then the block enters PAUSE.
- `loop_en` is sampled only at the final wrap.

## Timing
- Reset values: state IDLE, `note_div_left` = `note_div_right` = 1, `beat_idx` = 0, `playing` = 0, `done` = 0.
- `playing` and `done` are registered and assert in the same cycle the state register changes.
- `beat_idx` changes on the edge after `bcnt` = BEAT_DIV−1 is observed.
- `note_div_*` reflect the new `beat_idx` one cycle later (registered lookup). Likewise they reflect the first entry one cycle after entering PLAY.
- On entering IDLE, PAUSE or DONE, `note_div_*` = 1 from the next edge.
- Async `rst` mid-beat: all outputs go to reset values immediately.

## Configuration
Macro: `TONE_SEQ_GAP_EN`.
- Defined: in PLAY, when `bcnt` ≥ BEAT_DIV − GAP_CYC, both `note_div_*` = 1. This separates repeated notes; `beat_idx` timing is unchanged.
- Not defined: the note is held for the full beat, and `GAP_CYC` is ignored.

## Test plan
Bench settings: BEAT_DIV = 10, SONG_LEN = 4, GAP_CYC = 3.
1. Reset, then `play_en` = 1 → `playing` = 1 next cycle. One cycle later `note_div_left` = 113635 and `note_div_right` = 191109. After 10 PLAY cycles, `beat_idx` = 1, and one cycle later left = 56817, right = 1.
2. `play_en` = 0 mid-beat at `bcnt` = 4 for 20 cycles → both outputs 1, `beat_idx` frozen. On re-enable, the next beat change occurs after exactly 6 more PLAY cycles.
3. `loop_en` = 0, play 40 PLAY cycles → `done` = 1, `beat_idx` = 3, outputs 1. Toggling `play_en` has no effect; `rewind` → IDLE, `beat_idx` = 0.
4. `loop_en` = 1 → after entry 3, `beat_idx` = 0, `playing` stays 1, `done` never asserts.
5. `rewind` and a beat wrap in the same cycle → IDLE, `beat_idx` = 0. Async `rst` pulse mid-beat → immediate reset values.
6. With `TONE_SEQ_GAP_EN` → for `bcnt` 7..9 outputs = 1, otherwise ROM values. Without the macro → no gap.
